// File: rtl/serial_array_pkg.sv
// serial_array_pkg: shared types and helpers for the serial-to-array receive path.
// Holds default geometry, the packed frame type, FSM states and index mapping.
package serial_array_pkg;

    localparam int LANES_DEF = 4;
    localparam int ROWS_DEF  = 2;
    localparam int COLS_DEF  = 3;

    typedef logic [LANES_DEF-1:0][ROWS_DEF-1:0][COLS_DEF-1:0] arr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int flat_idx(
        input int l,
        input int r,
        input int c,
        input int rows,
        input int cols
    );
        return (l * rows + r) * cols + c;
    endfunction

endpackage

// File: rtl/serial_array_hold.sv
// serial_array_hold: one-entry valid/ready output register.
// A load in the same cycle as a drain replaces the entry without a bubble.
module serial_array_hold #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            dout      <= din;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_array_assembler.sv
// serial_array_assembler: rebuilds framed MSB-first serial bits into a
// packed LANES x ROWS x COLS array behind a one-entry output register.
module serial_array_assembler
    import serial_array_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ser_valid,
    output logic                                ser_ready,
    input  logic                                ser_bit,
    input  logic                                ser_first,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0][ROWS-1:0][COLS-1:0] arr_out,
    output logic                                err_stray,
    output logic                                err_resync
);

    localparam int W  = LANES * ROWS * COLS;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    if (W < 2) begin : g_w_check
        $error("serial_array_assembler: frame length W must be >= 2");
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-2:0]    sreg_q, sreg_d;
    logic            stray_d, resync_d;
    logic            acc, last, load;
    logic [W-1:0]    frame, hold_q;

    assign last      = (state_q == SHIFT) && (cnt_q == LAST);
    assign ser_ready = !(last && out_valid && !out_ready);
    assign acc       = ser_valid && ser_ready;
    assign frame     = {sreg_q, ser_bit};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        stray_d  = 1'b0;
        resync_d = 1'b0;
        load     = 1'b0;
        if (acc) begin
            unique case (1'b1)
                ser_first: begin
                    // a first bit always restarts, dropping any partial frame
                    sreg_d   = (W-1)'(ser_bit);
                    cnt_d    = CW'(1);
                    state_d  = SHIFT;
                    resync_d = (state_q == SHIFT);
                end
                (!ser_first && state_q == IDLE): begin
                    stray_d = 1'b1;
                end
                (!ser_first && last): begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    sreg_d = frame[W-2:0];
                    cnt_d  = cnt_q + CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            err_stray  <= 1'b0;
            err_resync <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            err_stray  <= stray_d;
            err_resync <= resync_d;
        end
    end

    serial_array_hold #(.W(W)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       (frame),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (hold_q)
    );

    always_comb begin
        arr_out = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    arr_out[l][r][c] = hold_q[flat_idx(l, r, c, ROWS, COLS)];
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_array_assembler.sv
// tb_serial_array_assembler: directed and randomized checks of the
// serial-to-array assembler with an in-order frame scoreboard.
module tb_serial_array_assembler;
    import serial_array_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_valid = 1'b0;
    logic ser_bit = 1'b0;
    logic ser_first = 1'b0;
    logic out_ready = 1'b0;
    logic ser_ready, out_valid, err_stray, err_resync;
    arr_t arr_out;

    int checks = 0;
    int errors = 0;
    int n_stray = 0;
    int n_resync = 0;
    int stalls = 0;
    int s0, r0;
    bit gaps = 1'b0;
    bit rnd_en = 1'b0;
    bit hold_prev = 1'b0;
    logic [23:0] held;
    logic [23:0] expq[$];
    logic [23:0] d;

    always #5 clk = ~clk;

    serial_array_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_bit    (ser_bit),
        .ser_first  (ser_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .arr_out    (arr_out),
        .err_stray  (err_stray),
        .err_resync (err_resync)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // output monitor: drains, hold stability, error pulse counts
    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            hold_prev = 1'b0;
            continue;
        end
        if (err_stray) n_stray++;
        if (err_resync) n_resync++;
        if (err_stray || err_resync)
            chk("err_excl", 32'(err_stray & err_resync), 32'h0);
        if (hold_prev) begin
            chk("hold_stable", 32'(arr_out), 32'(held));
            chk("hold_valid", 32'(out_valid), 32'h1);
        end
        if (out_valid && out_ready) begin
            if (expq.size() == 0)
                chk("unexpected_frame", 32'(arr_out), 32'hFFFF_FFFF);
            else
                chk("frame", 32'(arr_out), 32'(expq.pop_front()));
        end
        hold_prev = out_valid && !out_ready;
        held = arr_out;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_bit(input logic b, input logic f);
        if (gaps && $urandom_range(0, 1) == 1) begin
            ser_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        ser_valid = 1'b1;
        ser_bit   = b;
        ser_first = f;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (ser_ready) break;
            stalls++;
            if (i == 1000) begin
                chk("bit_timeout", 32'(ser_ready), 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    task automatic send_range(input logic [23:0] v, input int from,
                              input int upto);
        for (int p = from; p < upto; p++)
            send_bit(v[23-p], p == 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ready", 32'(ser_ready), 32'h1);
        chk("rst_arr", 32'(arr_out), 32'h0);
        chk("rst_err", 32'({err_stray, err_resync}), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single frame, consumer always ready
        out_ready = 1'b1;
        expq.push_back(24'hA5C3F0);
        send_range(24'hA5C3F0, 0, 23);
        chk("t1_pre_valid", 32'(out_valid), 32'h0);
        send_bit(1'b0, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_arr", 32'(arr_out), 32'h00A5C3F0);
        chk("t1_l3r1", 32'(arr_out[3][1]), 32'h5);
        chk("t1_l0r0", 32'(arr_out[0][0]), 32'h0);
        @(posedge clk);
        #1;

        // back-to-back frames against a stalled consumer
        out_ready = 1'b0;
        chk("t2_empty", 32'(out_valid), 32'h0);
        expq.push_back(24'h000001);
        expq.push_back(24'hFFFFFE);
        send_range(24'h000001, 0, 24);
        chk("t2_first_valid", 32'(out_valid), 32'h1);
        chk("t2_first_arr", 32'(arr_out), 32'h000001);
        stalls = 0;
        send_range(24'hFFFFFE, 0, 23);
        chk("t2_no_early_stall", 32'(stalls), 32'h0);
        ser_valid = 1'b1;
        ser_bit   = 1'b0;
        ser_first = 1'b0;
        @(negedge clk);
        chk("t2_stall_a", 32'(ser_ready), 32'h0);
        @(negedge clk);
        chk("t2_stall_b", 32'(ser_ready), 32'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_release", 32'(ser_ready), 32'h1);
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        chk("t2_nobubble", 32'(out_valid), 32'h1);
        chk("t2_second_arr", 32'(arr_out), 32'hFFFFFE);
        @(posedge clk);
        #1;
        chk("t2_drained", 32'(out_valid), 32'h0);

        // stray bits while idle
        s0 = n_stray;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_stray_cnt", 32'(n_stray - s0), 32'h3);
        chk("t3_no_valid", 32'(out_valid), 32'h0);
        expq.push_back(24'h123456);
        send_range(24'h123456, 0, 24);
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_arr", 32'(arr_out), 32'h123456);

        // resync in the middle of a frame
        r0 = n_resync;
        s0 = n_stray;
        send_range(24'h555555, 0, 10);
        expq.push_back(24'hDEADBE);
        send_range(24'hDEADBE, 0, 24);
        chk("t4_valid", 32'(out_valid), 32'h1);
        chk("t4_arr", 32'(arr_out), 32'hDEADBE);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_resync_cnt", 32'(n_resync - r0), 32'h1);
        chk("t4_stray_cnt", 32'(n_stray - s0), 32'h0);
        chk("t4_drained", 32'(out_valid), 32'h0);

        // asynchronous reset mid-frame, then with a held frame
        send_range(24'h3C3C3C, 0, 12);
        #1 rst = 1'b1;
        #1;
        chk("t5a_valid", 32'(out_valid), 32'h0);
        chk("t5a_ready", 32'(ser_ready), 32'h1);
        expq.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expq.push_back(24'h777777);
        send_range(24'h777777, 0, 24);
        chk("t5b_held", 32'(out_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t5b_valid", 32'(out_valid), 32'h0);
        chk("t5b_arr", 32'(arr_out), 32'h0);
        chk("t5b_ready", 32'(ser_ready), 32'h1);
        chk("t5b_err", 32'({err_stray, err_resync}), 32'h0);
        expq.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expq.push_back(24'h0F0F0F);
        send_range(24'h0F0F0F, 0, 24);
        chk("t5_valid", 32'(out_valid), 32'h1);
        chk("t5_arr", 32'(arr_out), 32'h0F0F0F);
        @(posedge clk);
        #1;

        // randomized gaps and backpressure
        s0 = n_stray;
        r0 = n_resync;
        gaps = 1'b1;
        rnd_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            d = 24'($urandom);
            expq.push_back(d);
            send_range(d, 0, 24);
        end
        gaps = 1'b0;
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (expq.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("t6_drain_empty", 32'(expq.size()), 32'h0);
        chk("t6_no_stray", 32'(n_stray - s0), 32'h0);
        chk("t6_no_resync", 32'(n_resync - r0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_array_assembler.md
Name: serial_array_assembler

Overview:
- Receive-side counterpart of the packed-array-to-serial path.
- Collects a framed 1-bit serial stream and reassembles it into a packed 3-D array of LANES x ROWS x COLS bits (default 4x2x3 = 24 bits).
- Presents each completed array on a valid/ready output with a one-entry holding register.
- Sits between a bit-serial link and any consumer of packed multi-dimensional vectors.

Parameters:
- LANES, 4, outermost packed dimension (lane count).
- ROWS, 2, middle packed dimension.
- COLS, 3, innermost packed dimension (element width).
- Derived, not overridable: W = LANES*ROWS*COLS (frame length in bits); CW = $clog2(W) (counter width).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ser_valid  input  1  serial bit offered this cycle.
- ser_ready  output  1  assembler can accept a bit this cycle.
- ser_bit  input  1  serial data, MSB of the flattened frame first.
- ser_first  input  1  marks the first bit of a frame; qualified by ser_valid.
- out_valid  output  1  arr_out holds a complete frame.
- out_ready  input  1  consumer accepts arr_out.
- arr_out  output  [LANES-1:0][ROWS-1:0][COLS-1:0]  assembled frame.
- err_stray  output  1  one-cycle pulse: a non-first bit was accepted while IDLE.
- err_resync  output  1  one-cycle pulse: ser_first was accepted mid-frame.

Behaviour:
- Reset values: state=IDLE, cnt=0, shift register=0, arr_out=0, out_valid=0, err_stray=0, err_resync=0, ser_ready=1.
- Bit transfer occurs only when ser_valid && ser_ready. Output transfer occurs only when out_valid && out_ready.
- Flattened bit mapping: flat index = (l*ROWS + r)*COLS + c. The first serial bit lands at index W-1, i.e. arr_out[LANES-1][ROWS-1][COLS-1].
- IDLE:
  - Accept with ser_first=1: store bit, cnt<=1, go to SHIFT.
  - Accept with ser_first=0: discard the bit, pulse err_stray, stay in IDLE.
- SHIFT:
  - Accept with ser_first=0: shift the bit in, cnt<=cnt+1.
  - Accept with ser_first=1: discard the partial frame, pulse err_resync, store the bit as the new first bit, cnt<=1, stay in SHIFT.
  - Accept when cnt==W-1 and ser_first=0 (frame complete): load the full frame into arr_out, out_valid<=1, cnt<=0, go to IDLE.
- Latency: last bit accepted in cycle N -> out_valid=1 and arr_out valid in cycle N+1.
- Backpressure: ser_ready = !(state==SHIFT && cnt==W-1 && out_valid && !out_ready). Only the completing bit stalls. All earlier bits flow while the holding register is full.
- Holding register release:
  - out_valid && out_ready with no completion that cycle: out_valid<=0.
  - Drain and completion in the same cycle: arr_out<=new frame, out_valid stays 1. No bubble, no loss.
- arr_out is stable while out_valid && !out_ready.
- Frames of W=1 are not supported. The block must assert W>=2 at elaboration.
- Reset mid-frame: partial frame and holding register are dropped, and all outputs return to their reset values.
- err_* pulses last exactly one cycle. Both pulses are never high in the same cycle.

Decomposition:
- Package serial_array_pkg holds:
  - default LANES/ROWS/COLS;
  - typedef arr_t (the packed 3-D array);
  - state enum {IDLE, SHIFT};
  - the flat-index helper function.
- One sub-module, serial_array_hold, is natural: the one-entry valid/ready output register with simultaneous drain/load.

Test Plan:
- Reset, then send 0xA5C3F0 MSB first (ser_first on bit 0), out_ready=1 -> out_valid one cycle after the 24th bit; arr_out=24'hA5C3F0; arr_out[3][1]=3'b101; arr_out[0][0]=3'b000.
- Two back-to-back frames 0x000001 and 0xFFFFFE, out_ready=0 until the second frame's 24th bit is offered -> ser_ready low on that bit only; raise out_ready -> first frame 0x000001 drained, then 0xFFFFFE appears with no bubble and no loss.
- Three bits with ser_first=0 while IDLE -> three err_stray pulses, out_valid stays 0, next proper frame 0x123456 assembled correctly.
- Send 10 bits of a frame, then ser_first=1 and a full frame 0xDEADBE -> err_resync pulses once, output 0xDEADBE, and no output for the partial frame.
- Assert rst asynchronously (mid-cycle) after 12 bits and again while out_valid=1 -> out_valid, arr_out and cnt clear immediately; the following frame 0x0F0F0F is assembled correctly.
- Random ser_valid/out_ready gaps (≈50% duty) over 200 frames -> scoreboard matches every frame in order, and arr_out never changes while out_valid && !out_ready.
